// File: rtl/mac_pkt_loopback_pkg.sv
// Shared types and defaults for the MAC receive-to-transmit frame loopback.
// Holds the receive FSM encoding, the buffered word layout and a saturating counter helper.
package mac_pkt_loopback_pkg;

   localparam int unsigned DEF_FIFO_AW   = 8;
   localparam int unsigned DEF_MAX_WORDS = 192;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READ    = 2'd1,
      ST_DISCARD = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  mod;
      logic        sop;
      logic        eop;
   } fifo_word_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, v} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/mac_pkt_fifo_ram.sv
// Simple dual-port frame buffer: synchronous write port, asynchronous read port.
module mac_pkt_fifo_ram
   import mac_pkt_loopback_pkg::*;
#(
   parameter int unsigned AW = DEF_FIFO_AW
)(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fifo_word_t    wdata,
   input  logic [AW-1:0] raddr,
   output fifo_word_t    rdata
);

   fifo_word_t mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = mem_q[raddr];
   end

endmodule

// File: rtl/mac_pkt_loopback.sv
// Store-and-forward loopback: frames read from the MAC receive side are buffered and
// only released to the transmit side once their eop has been committed without error.
module mac_pkt_loopback
   import mac_pkt_loopback_pkg::*;
#(
   parameter int unsigned FIFO_AW   = DEF_FIFO_AW,
   parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
)(
   input  logic        clk_156m25,
   input  logic        reset_156m25,
   input  logic        pkt_rx_avail,
   output logic        pkt_rx_ren,
   input  logic [63:0] pkt_rx_data,
   input  logic [2:0]  pkt_rx_mod,
   input  logic        pkt_rx_val,
   input  logic        pkt_rx_sop,
   input  logic        pkt_rx_eop,
   input  logic        pkt_rx_err,
   output logic [63:0] pkt_tx_data,
   output logic [2:0]  pkt_tx_mod,
   output logic        pkt_tx_val,
   output logic        pkt_tx_sop,
   output logic        pkt_tx_eop,
   input  logic        pkt_tx_full,
   output logic [15:0] frames_fwd,
   output logic [15:0] frames_drop
);

   localparam int unsigned PTR_W = FIFO_AW + 1;
   localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(2**FIFO_AW);
   localparam logic [PTR_W-1:0] MAXW_P  = PTR_W'(MAX_WORDS);
   localparam logic [CNT_W-1:0] MAXW_C  = CNT_W'(MAX_WORDS);

   rx_state_e        state_q, state_d;
   logic [PTR_W-1:0] wr_spec_q, wr_spec_d;
   logic [PTR_W-1:0] wr_cmt_q, wr_cmt_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic [15:0]      fwd_q, fwd_d;
   logic [15:0]      drop_q, drop_d;

   logic [PTR_W-1:0] used, free, base_ptr, next_ptr;
   logic [CNT_W-1:0] base_cnt, next_cnt;
   logic             restart, fwd_inc, ram_we, fifo_empty, fifo_full;
   logic [1:0]       drop_inc;
   fifo_word_t       ram_wdata, head;

   always_comb begin
      used       = wr_cmt_q - rd_q;
      free       = DEPTH_P - used;
      fifo_empty = (rd_q == wr_cmt_q);
      fifo_full  = (rd_q[FIFO_AW] != wr_cmt_q[FIFO_AW]) &&
                   (rd_q[FIFO_AW-1:0] == wr_cmt_q[FIFO_AW-1:0]);
   end

   // A sop arriving mid-frame abandons the partial frame and restarts at the committed pointer.
   always_comb begin
      state_d   = state_q;
      wr_spec_d = wr_spec_q;
      wr_cmt_d  = wr_cmt_q;
      wcnt_d    = wcnt_q;
      fwd_inc   = 1'b0;
      drop_inc  = 2'd0;
      ram_we    = 1'b0;
      restart   = pkt_rx_sop && (wcnt_q != '0);
      base_ptr  = restart ? wr_cmt_q : wr_spec_q;
      base_cnt  = restart ? '0 : wcnt_q;
      next_ptr  = base_ptr + PTR_W'(1);
      next_cnt  = base_cnt + CNT_W'(1);
      ram_wdata = '{data: pkt_rx_data, mod: pkt_rx_mod, sop: pkt_rx_sop, eop: pkt_rx_eop};

      case (state_q)
         ST_IDLE: begin
            if (pkt_rx_avail && !fifo_full && (free >= MAXW_P)) begin
               state_d   = ST_READ;
               wcnt_d    = '0;
               wr_spec_d = wr_cmt_q;
            end
         end
         ST_READ: begin
            if (pkt_rx_val) begin
               ram_we = 1'b1;
               if (restart) begin
                  drop_inc = 2'd1;
               end
               if (pkt_rx_eop) begin
                  state_d = ST_IDLE;
                  wcnt_d  = '0;
                  if (pkt_rx_err) begin
                     wr_spec_d = wr_cmt_q;
                     drop_inc  = drop_inc + 2'd1;
                  end else begin
                     wr_spec_d = next_ptr;
                     wr_cmt_d  = next_ptr;
                     fwd_inc   = 1'b1;
                  end
               end else if (next_cnt == MAXW_C) begin
                  wr_spec_d = wr_cmt_q;
                  wcnt_d    = '0;
                  state_d   = ST_DISCARD;
               end else begin
                  wr_spec_d = next_ptr;
                  wcnt_d    = next_cnt;
               end
            end
         end
         ST_DISCARD: begin
            if (pkt_rx_val && pkt_rx_eop) begin
               drop_inc = 2'd1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      fwd_d  = sat_add16(fwd_q, {1'b0, fwd_inc});
      drop_d = sat_add16(drop_q, drop_inc);
   end

   always_comb begin
      pkt_rx_ren  = (state_q == ST_READ) || (state_q == ST_DISCARD);
      pkt_tx_val  = !fifo_empty && !pkt_tx_full;
      rd_d        = pkt_tx_val ? (rd_q + PTR_W'(1)) : rd_q;
      pkt_tx_data = head.data;
      pkt_tx_mod  = head.eop ? head.mod : '0;
      pkt_tx_sop  = head.sop;
      pkt_tx_eop  = head.eop;
      frames_fwd  = fwd_q;
      frames_drop = drop_q;
   end

   always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
      if (reset_156m25) begin
         state_q   <= ST_IDLE;
         wr_spec_q <= '0;
         wr_cmt_q  <= '0;
         rd_q      <= '0;
         wcnt_q    <= '0;
         fwd_q     <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         wr_spec_q <= wr_spec_d;
         wr_cmt_q  <= wr_cmt_d;
         rd_q      <= rd_d;
         wcnt_q    <= wcnt_d;
         fwd_q     <= fwd_d;
         drop_q    <= drop_d;
      end
   end

   mac_pkt_fifo_ram #(
      .AW (FIFO_AW)
   ) u_ram (
      .clk   (clk_156m25),
      .we    (ram_we),
      .waddr (base_ptr[FIFO_AW-1:0]),
      .wdata (ram_wdata),
      .raddr (rd_q[FIFO_AW-1:0]),
      .rdata (head)
   );

endmodule

// File: tb/tb_mac_pkt_loopback.sv
// Scoreboard bench: a MAC model feeds randomized frames, expected transmit words are
// queued when a forwardable frame's eop is accepted, and a monitor checks every tx word.
module tb_mac_pkt_loopback;

   localparam int DEPTH = 256;
   localparam int MAXW  = 192;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  mod;
      logic        sop;
      logic        eop;
      logic        err;
      logic        fwd;
   } rx_item_t;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  mod;
      logic        sop;
      logic        eop;
   } tx_item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pkt_rx_avail = 1'b0;
   logic        pkt_rx_ren;
   logic [63:0] pkt_rx_data = '0;
   logic [2:0]  pkt_rx_mod = '0;
   logic        pkt_rx_val = 1'b0;
   logic        pkt_rx_sop = 1'b0;
   logic        pkt_rx_eop = 1'b0;
   logic        pkt_rx_err = 1'b0;
   logic [63:0] pkt_tx_data;
   logic [2:0]  pkt_tx_mod;
   logic        pkt_tx_val;
   logic        pkt_tx_sop;
   logic        pkt_tx_eop;
   logic        pkt_tx_full = 1'b0;
   logic [15:0] frames_fwd;
   logic [15:0] frames_drop;

   rx_item_t rx_q[$];
   tx_item_t pend_q[$];
   tx_item_t exp_q[$];

   int n_tests  = 0;
   int n_fail   = 0;
   int exp_fwd  = 0;
   int exp_drop = 0;
   int consumed = 0;
   int bubble_pct = 20;
   int full_pct   = 15;
   bit presented  = 1'b0;
   bit full_hold  = 1'b0;
   bit ren_prev   = 1'b0;

   mac_pkt_loopback #(
      .FIFO_AW   (8),
      .MAX_WORDS (MAXW)
   ) dut (
      .clk_156m25   (clk),
      .reset_156m25 (rst),
      .pkt_rx_avail (pkt_rx_avail),
      .pkt_rx_ren   (pkt_rx_ren),
      .pkt_rx_data  (pkt_rx_data),
      .pkt_rx_mod   (pkt_rx_mod),
      .pkt_rx_val   (pkt_rx_val),
      .pkt_rx_sop   (pkt_rx_sop),
      .pkt_rx_eop   (pkt_rx_eop),
      .pkt_rx_err   (pkt_rx_err),
      .pkt_tx_data  (pkt_tx_data),
      .pkt_tx_mod   (pkt_tx_mod),
      .pkt_tx_val   (pkt_tx_val),
      .pkt_tx_sop   (pkt_tx_sop),
      .pkt_tx_eop   (pkt_tx_eop),
      .pkt_tx_full  (pkt_tx_full),
      .frames_fwd   (frames_fwd),
      .frames_drop  (frames_drop)
   );

   always #3 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   // A frame is forwarded only if it ends in a clean eop and fits the size limit;
   // truncated frames are always followed by another frame whose sop abandons them.
   task automatic send_frame(input int len, input bit err, input bit trunc, input int eop_mod);
      bit good;
      good = !err && !trunc && (len <= MAXW);
      for (int i = 0; i < len; i++) begin
         rx_item_t w;
         w.data = {$urandom, $urandom};
         w.sop  = (i == 0);
         w.eop  = (i == len - 1) && !trunc;
         w.mod  = (w.eop && eop_mod >= 0) ? 3'(eop_mod) : 3'($urandom_range(7));
         w.err  = w.eop ? err : 1'($urandom_range(1));
         w.fwd  = good;
         rx_q.push_back(w);
      end
      if (good) exp_fwd++;
      else exp_drop++;
   endtask

   task automatic drain(input string name, input int budget);
      int cyc;
      bit busy;
      cyc  = 0;
      busy = 1'b1;
      while (busy && cyc < budget) begin
         @(negedge clk);
         cyc++;
         busy = (rx_q.size() != 0) || presented || (pend_q.size() != 0) || (exp_q.size() != 0);
      end
      check({name, " drain_timeout"}, 64'(busy), 64'(0));
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic check_counts(input string name);
      check({name, " frames_fwd"}, 64'(frames_fwd), 64'(exp_fwd));
      check({name, " frames_drop"}, 64'(frames_drop), 64'(exp_drop));
   endtask

   // MAC receive model and transmit back-pressure, driven just after each rising edge.
   initial begin : mac_model
      forever begin
         @(posedge clk);
         #1;
         if (presented && !rst) begin
            rx_item_t w;
            tx_item_t t;
            w = rx_q.pop_front();
            consumed++;
            if (w.fwd) begin
               t.data = w.data;
               t.mod  = w.eop ? w.mod : 3'd0;
               t.sop  = w.sop;
               t.eop  = w.eop;
               pend_q.push_back(t);
               if (w.eop) begin
                  while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
               end
            end
         end
         presented  = 1'b0;
         pkt_rx_val = 1'b0;
         pkt_rx_sop = 1'b0;
         pkt_rx_eop = 1'b0;
         pkt_rx_err = 1'b0;
         if (!rst && pkt_rx_ren && rx_q.size() != 0 && int'($urandom_range(99)) >= bubble_pct) begin
            pkt_rx_data = rx_q[0].data;
            pkt_rx_mod  = rx_q[0].mod;
            pkt_rx_sop  = rx_q[0].sop;
            pkt_rx_eop  = rx_q[0].eop;
            pkt_rx_err  = rx_q[0].err;
            pkt_rx_val  = 1'b1;
            presented   = 1'b1;
         end
         pkt_rx_avail = (rx_q.size() != 0);
         pkt_tx_full  = full_hold || (int'($urandom_range(99)) < full_pct);
      end
   end

   always @(negedge clk) begin : monitor
      if (rst) begin
         ren_prev = 1'b0;
      end else begin
         if (pkt_rx_ren && !ren_prev)
            check("rx_ren_needs_space", 64'(exp_q.size() <= DEPTH - MAXW), 64'(1));
         ren_prev = pkt_rx_ren;
         if (pkt_tx_full)
            check("tx_val_while_full", 64'(pkt_tx_val), 64'(0));
         if (pkt_tx_val) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL tx_unexpected: got word 0x%0h, want no word", pkt_tx_data);
            end else begin
               tx_item_t e;
               e = exp_q.pop_front();
               check("tx_data", pkt_tx_data, e.data);
               check("tx_mod", 64'(pkt_tx_mod), 64'(e.mod));
               check("tx_sop", 64'(pkt_tx_sop), 64'(e.sop));
               check("tx_eop", 64'(pkt_tx_eop), 64'(e.eop));
            end
         end
      end
   end

   initial begin : main
      int cyc;
      int sz;
      int c0;
      bit trunc;

      repeat (3) @(negedge clk);
      #1;
      check("reset rx_ren", 64'(pkt_rx_ren), 64'(0));
      check("reset tx_val", 64'(pkt_tx_val), 64'(0));
      check_counts("reset");
      send_frame(8, 1'b0, 1'b0, 3);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("post_reset rx_ren", 64'(pkt_rx_ren), 64'(0));
      check("post_reset tx_val", 64'(pkt_tx_val), 64'(0));
      drain("good8", 2000);
      check_counts("good8");

      send_frame(5, 1'b1, 1'b0, -1);
      drain("err5", 2000);
      check_counts("err5");

      send_frame(200, 1'b0, 1'b0, -1);
      send_frame(4, 1'b0, 1'b0, -1);
      drain("long200", 4000);
      check_counts("long200");

      send_frame(192, 1'b0, 1'b0, 0);
      drain("exact192", 4000);
      send_frame(193, 1'b0, 1'b0, -1);
      send_frame(1, 1'b0, 1'b0, 5);
      drain("over193", 4000);
      check_counts("boundary");

      full_pct = 0;
      send_frame(40, 1'b0, 1'b0, -1);
      cyc = 0;
      while (!(exp_q.size() > 0 && exp_q.size() <= 30) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("full_hold reached mid-frame", 64'(cyc < 2000), 64'(1));
      #1 full_hold = 1'b1;
      @(posedge clk);
      #2 sz = exp_q.size();
      repeat (20) @(negedge clk);
      #1;
      check("full_hold no_pop", 64'(exp_q.size()), 64'(sz));
      full_hold = 1'b0;
      full_pct  = 15;
      drain("full_hold", 2000);
      check_counts("full_hold");

      send_frame(3, 1'b0, 1'b1, -1);
      send_frame(6, 1'b0, 1'b0, -1);
      drain("restart_sop", 2000);
      check_counts("restart_sop");

      bubble_pct = 25;
      full_pct   = 20;
      for (int i = 0; i < 40; i++) begin
         trunc = ($urandom_range(9) == 0) && (i != 39);
         send_frame(int'($urandom_range(1, 24)), ($urandom_range(9) == 0), trunc, -1);
      end
      drain("random", 8000);
      check_counts("random");

      bubble_pct = 5;
      full_pct   = 10;
      for (int i = 0; i < 300; i++) send_frame(64, 1'b0, 1'b0, -1);
      drain("b2b300", 60000);
      check_counts("b2b300");

      bubble_pct = 10;
      send_frame(40, 1'b0, 1'b0, -1);
      c0  = consumed;
      cyc = 0;
      while (consumed < c0 + 10 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      #1;
      check("pre_reset rx_ren", 64'(pkt_rx_ren), 64'(1));
      #1 rst = 1'b1;
      #1;
      check("async_reset rx_ren", 64'(pkt_rx_ren), 64'(0));
      check("async_reset tx_val", 64'(pkt_tx_val), 64'(0));
      check("async_reset frames_fwd", 64'(frames_fwd), 64'(0));
      check("async_reset frames_drop", 64'(frames_drop), 64'(0));
      rx_q.delete();
      pend_q.delete();
      exp_q.delete();
      exp_fwd  = 0;
      exp_drop = 0;
      send_frame(6, 1'b0, 1'b0, 7);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rerelease rx_ren", 64'(pkt_rx_ren), 64'(0));
      check("rerelease tx_val", 64'(pkt_tx_val), 64'(0));
      drain("after_reset", 2000);
      check_counts("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
